// File: rtl/fp52_pack.sv
// fp52_pack: sums up to ACC_LEN 18-bit beats, shifts by cfg_shift, encodes to 6b fraction + 2b exponent; out_valid 2 cycles after closing beat.
// in_ready only while accumulating; output held until out_ready. Define FP52_PACK_RNE_EN for round-nearest-even, else truncate.
module fp52_pack #(
  parameter int ACC_LEN = 4,
  parameter int ACC_W   = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] in_dat,
  input  logic        in_last,
  input  logic [3:0]  cfg_shift,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_dat,
  output logic [1:0]  out_exp,
  output logic        out_sat
);

  typedef enum logic [1:0] {ST_ACC, ST_ENC, ST_OUT} state_t;

  localparam logic [7:0] LEN = 8'(ACC_LEN);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [3:0]       shift_q, shift_d;
  logic             ovf_q, ovf_d;
  logic [5:0]       dat_q, dat_d;
  logic [1:0]       exp_q, exp_d;
  logic             sat_q, sat_d;

  logic             first_beat;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   acc_sum;

  // The first beat of a group starts from zero so a stale sum never leaks in.
  assign first_beat = (cnt_q == 8'd0);
  assign acc_base   = first_beat ? '0 : acc_q;
  assign acc_sum    = {1'b0, acc_base} + {{(ACC_W + 1 - 18){1'b0}}, in_dat};

  logic [ACC_W-1:0] v;
  logic [1:0]       enc_e;
  logic             enc_big;
  logic [5:0]       enc_trunc;
  logic             enc_rnd;
  logic [6:0]       enc_rsum;
  logic [5:0]       enc_dat;
  logic [1:0]       enc_exp;
  logic             enc_sat;

  assign v = acc_q >> shift_q;

  always_comb begin
    enc_big   = 1'b0;
    enc_e     = 2'd0;
    enc_trunc = v[5:0];
    if (v[ACC_W-1:6] == '0) begin
      enc_e     = 2'd0;
      enc_trunc = v[5:0];
    end else if (v[ACC_W-1:7] == '0) begin
      enc_e     = 2'd1;
      enc_trunc = v[6:1];
    end else if (v[ACC_W-1:8] == '0) begin
      enc_e     = 2'd2;
      enc_trunc = v[7:2];
    end else if (v[ACC_W-1:9] == '0) begin
      enc_e     = 2'd3;
      enc_trunc = v[8:3];
    end else begin
      enc_big   = 1'b1;
    end
  end

`ifdef FP52_PACK_RNE_EN
  logic rnd_guard;
  logic rnd_sticky;

  always_comb begin
    rnd_guard  = 1'b0;
    rnd_sticky = 1'b0;
    case (enc_e)
      2'd1: rnd_guard = v[0];
      2'd2: begin
        rnd_guard  = v[1];
        rnd_sticky = v[0];
      end
      2'd3: begin
        rnd_guard  = v[2];
        rnd_sticky = |v[1:0];
      end
      default: ;
    endcase
    enc_rnd = rnd_guard & (rnd_sticky | enc_trunc[0]);
  end
`else
  assign enc_rnd = 1'b0;
`endif

  assign enc_rsum = {1'b0, enc_trunc} + {6'd0, enc_rnd};

  // A round-up carry to 64 renormalises to 32 at the next exponent, saturating past e=3.
  always_comb begin
    enc_dat = enc_rsum[5:0];
    enc_exp = enc_e;
    enc_sat = 1'b0;
    if (enc_big || (enc_rsum[6] && enc_e == 2'd3)) begin
      enc_dat = 6'd63;
      enc_exp = 2'd3;
      enc_sat = 1'b1;
    end else if (enc_rsum[6]) begin
      enc_dat = 6'd32;
      enc_exp = enc_e + 2'd1;
    end
    if (ovf_q) begin
      enc_sat = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ovf_d     = ovf_q;
    dat_d     = dat_q;
    exp_d     = exp_q;
    sat_d     = sat_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (first_beat) begin
            shift_d = cfg_shift;
          end
          ovf_d = (first_beat ? 1'b0 : ovf_q) | acc_sum[ACC_W];
          acc_d = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == LEN || in_last) begin
            state_d = ST_ENC;
          end
        end
      end
      ST_ENC: begin
        dat_d   = enc_dat;
        exp_d   = enc_exp;
        sat_d   = enc_sat;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_ACC;
          cnt_d   = 8'd0;
          acc_d   = '0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= 8'd0;
      shift_q <= 4'd0;
      ovf_q   <= 1'b0;
      dat_q   <= 6'd0;
      exp_q   <= 2'd0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
      dat_q   <= dat_d;
      exp_q   <= exp_d;
      sat_q   <= sat_d;
    end
  end

  assign out_dat = dat_q;
  assign out_exp = exp_q;
  assign out_sat = sat_q;

endmodule

// File: doc/fp52_pack.md
FP52_PACK -- requirements
Module: fp52_pack

Interface
REQ-001 Parameter ACC_LEN, default 4: number of accepted inputs per output group (1..255).
REQ-002 Parameter ACC_W, default 24: accumulator width in bits (>=18).
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_dat valid.
REQ-006 in_ready  output  1  block accepts in_dat this cycle.
REQ-007 in_dat  input  18  unsigned fixed-point MAC result.
REQ-008 in_last  input  1  with accepted beat: closes group early.
REQ-009 cfg_shift  input  4  right-shift applied to the group sum before encoding.
REQ-010 out_valid  output  1  encoded operand valid.
REQ-011 out_ready  input  1  consumer accepts the output.
REQ-012 out_dat  output  6  fp52 fraction.
REQ-013 out_exp  output  2  fp52 exponent; value = out_dat << out_exp.
REQ-014 out_sat  output  1  output was saturated.

Function
REQ-015 A beat is accepted when in_valid and in_ready are both 1 on a posedge.
REQ-016 FSM states: ACC, ENC, OUT; in_ready = 1 only in ACC.
REQ-017 ACC: each accepted beat adds in_dat to acc (ACC_W bits); cnt increments.
REQ-018 ACC -> ENC on the accepted beat where cnt reaches ACC_LEN, or in_last = 1.
REQ-019 The first beat of a group loads acc = in_dat (no stale sum) and samples cfg_shift for the whole group.
REQ-020 Accumulator overflow clamps acc to 2^ACC_W-1 and forces out_sat = 1 for that group.
REQ-021 ENC lasts one cycle: V = acc >> cfg_shift (shifted-out bits discarded); the result is registered into out_*; ENC -> OUT.
REQ-022 Encode: e = smallest value in 0..3 with (V >> e) < 64; out_dat = rounded V >> e (REQ-030); e = 0 is exact.
REQ-023 If rounding yields 64: e = e+1, out_dat = 32; if e was already 3, saturate.
REQ-024 If (V >> 3) >= 64, or saturation per REQ-023: out_dat = 63, out_exp = 3, out_sat = 1.
REQ-025 OUT: out_valid = 1; out_dat/out_exp/out_sat are held stable until out_ready = 1; OUT -> ACC on handshake; cnt and acc cleared.
REQ-026 Latency: last beat accepted at cycle t -> out_valid = 1 at t+2 (earliest); throughput max one group per ACC_LEN+2 cycles.
REQ-027 out_valid is never deasserted without a handshake; in_valid while in ENC/OUT is ignored (not accepted).

Reset
REQ-028 rst_n = 0 asynchronously forces state ACC, acc = 0, cnt = 0, out_valid = 0, out_dat = 0, out_exp = 0, out_sat = 0; a partial group or pending output is discarded.
REQ-029 After rst_n deasserts, in_ready = 1 on the first clk edge.

Configuration
REQ-030 Macro FP52_PACK_RNE_EN defined: discarded bits of V >> e round to nearest, ties to even.
REQ-031 FP52_PACK_RNE_EN undefined: truncate (out_dat = V >> e); REQ-023 never triggers; all other behaviour identical.

Verification
REQ-032 ACC_LEN = 4, cfg_shift = 0, beats 10,20,30,3 -> out_dat = 63, out_exp = 0, out_sat = 0, out_valid 2 cycles after the 4th beat.
REQ-033 Beats 100,0,0,0 -> out_dat = 50, out_exp = 1, out_sat = 0.
REQ-034 Sum 127: with RNE_EN -> out_dat = 32, out_exp = 2; without -> out_dat = 63, out_exp = 1.
REQ-035 Sum 600 -> out_dat = 63, out_exp = 3, out_sat = 1; sum 1024 with cfg_shift = 2 -> out_dat = 32, out_exp = 3, out_sat = 0.
REQ-036 out_ready held 0 for 5 cycles -> out_* stable and in_ready = 0 throughout; beat 7 with in_last after 1 beat -> out_dat = 7, out_exp = 0, next group counts from 0.
REQ-037 rst_n pulsed low after 2 beats of a group -> out_valid = 0 immediately; the next 4 beats of 1 -> out_dat = 4.
